// File: rtl/minc_pkg.sv
// Shared types and instruction-field positions for the multi-cycle minc stack CPU.
// The 15-bit instruction layout is identical to the original single-cycle minc.
package minc_pkg;

  localparam int INSTR_W = 15;

  // Instruction field bit positions
  localparam int OP_HI   = 14;
  localparam int OP_LO   = 12;
  localparam int SUB_HI  = 11;
  localparam int SUB_LO  = 8;
  localparam int IMM_HI  = 11;
  localparam int IMM_LO  = 4;
  localparam int RDH_HI  = 7;
  localparam int RDH_LO  = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 0;

  // stm/ldm address off this register
  localparam logic [3:0] R_BASE = 4'hF;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000,
    OP_MVI  = 3'b001,
    OP_STM  = 3'b010,
    OP_LDM  = 3'b011,
    OP_JZ   = 3'b100,
    OP_CALL = 3'b101,
    OP_JNZ  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [3:0] {
    SUB_MOV  = 4'h0,
    SUB_ADD  = 4'h1,
    SUB_SUB  = 4'h2,
    SUB_CMP  = 4'h3,
    SUB_MUL  = 4'h4,
    SUB_PUSH = 4'h8,
    SUB_LDS  = 4'h9,
    SUB_POP  = 4'hA,
    SUB_STS  = 4'hB,
    SUB_RET  = 4'hC
  } subop_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    MEM    = 2'd2,
    HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/minc_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports, one synchronous
// write port, whole array cleared by the asynchronous reset.
module minc_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  localparam int RA_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [RA_W-1:0]   i_ra_addr,
  input  logic [RA_W-1:0]   i_rb_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_regs [NREGS];

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: this array is deliberately reset (software relies on regs=0 after
  // reset); that rules out a RAM macro, which is acceptable at 16 entries.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];

endmodule

// File: rtl/minc_core_mc.sv
// Multi-cycle minc stack CPU core: FETCH/DECODE/MEM/HALT sequencer with
// req/ack handshakes to external instruction and data memories.
module minc_core_mc
  import minc_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 8,
  parameter int          NREGS  = 16,
  parameter int unsigned SP_RST = 0
) (
  input  logic               CLK,
  input  logic               nRESET,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  sp_out,
  output logic               halted
);

  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e              r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_pc, r_sp;
  logic                r_dreq, r_dwe;
  logic [ADDR_W-1:0]   r_daddr;
  logic [DATA_W-1:0]   r_dwdata;

  logic [ADDR_W-1:0]   w_pc_nxt, w_sp_nxt, w_daddr_nxt;
  logic                w_dreq_nxt, w_dwe_nxt, w_ir_load, w_go_mem;
  logic [DATA_W-1:0]   w_dwdata_nxt;

  logic [ADDR_W-1:0]   w_pc_inc, w_sp_inc, w_sp_dec, w_ea;
  op_e                 w_op;
  subop_e              w_sub;
  logic [7:0]          w_imm;
  logic [RA_W-1:0]     w_rd, w_rs, w_ra_addr;
  logic [DATA_W-1:0]   w_ra_data, w_rb_data;

  logic                w_rf_we;
  logic [RA_W-1:0]     w_rf_wa;
  logic [DATA_W-1:0]   w_rf_wd;

  // Field decode straight from IR; IR stays valid through DECODE and MEM
  assign w_op  = op_e'(r_ir[OP_HI:OP_LO]);
  assign w_sub = subop_e'(r_ir[SUB_HI:SUB_LO]);
  assign w_imm = r_ir[IMM_HI:IMM_LO];
  assign w_rd  = r_ir[OP_LO] ? RA_W'(r_ir[RS_HI:RS_LO]) : RA_W'(r_ir[RDH_HI:RDH_LO]);
  assign w_rs  = RA_W'(r_ir[RS_HI:RS_LO]);

  assign w_ra_addr = (w_op == OP_STM || w_op == OP_LDM) ? RA_W'(R_BASE) : w_rd;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_sp_inc = r_sp + ADDR_W'(1);
  assign w_sp_dec = r_sp - ADDR_W'(1);
  assign w_ea     = ADDR_W'(w_ra_data) + ADDR_W'(w_imm);

  minc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .i_ra_addr (w_ra_addr),
    .i_rb_addr (w_rs),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .i_we      (w_rf_we),
    .i_wa      (w_rf_wa),
    .i_wd      (w_rf_wd)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can infer a latch.
    w_state_nxt  = r_state;
    w_ir_load    = 1'b0;
    w_pc_nxt     = r_pc;
    w_sp_nxt     = r_sp;
    w_dreq_nxt   = r_dreq;
    w_dwe_nxt    = r_dwe;
    w_daddr_nxt  = r_daddr;
    w_dwdata_nxt = r_dwdata;
    w_go_mem     = 1'b0;
    w_rf_we      = 1'b0;
    w_rf_wa      = w_rd;
    w_rf_wd      = '0;

    case (r_state)
      FETCH: begin
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = DECODE;
        end
      end

      DECODE: begin
        w_state_nxt = FETCH;
        w_pc_nxt    = w_pc_inc;
        case (w_op)
          OP_ALU: begin
            case (w_sub)
              SUB_MOV: begin w_rf_we = 1'b1; w_rf_wd = w_rb_data; end
              SUB_ADD: begin w_rf_we = 1'b1; w_rf_wd = w_ra_data + w_rb_data; end
              SUB_SUB: begin w_rf_we = 1'b1; w_rf_wd = w_ra_data - w_rb_data; end
              SUB_CMP: begin w_rf_we = 1'b1; w_rf_wd = DATA_W'(w_ra_data < w_rb_data); end
              SUB_MUL: begin w_rf_we = 1'b1; w_rf_wd = w_ra_data * w_rb_data; end
              SUB_LDS: w_sp_nxt = ADDR_W'(w_rb_data);
              SUB_STS: begin w_rf_we = 1'b1; w_rf_wd = DATA_W'(r_sp); end
              SUB_PUSH: begin
                w_go_mem     = 1'b1;
                w_dwe_nxt    = 1'b1;
                w_daddr_nxt  = w_sp_dec;
                w_dwdata_nxt = w_rb_data;
              end
              SUB_POP, SUB_RET: begin
                w_go_mem    = 1'b1;
                w_dwe_nxt   = 1'b0;
                w_daddr_nxt = r_sp;
              end
              default: ;
            endcase
          end
          OP_MVI: begin w_rf_we = 1'b1; w_rf_wd = DATA_W'(w_imm); end
          OP_STM: begin
            w_go_mem     = 1'b1;
            w_dwe_nxt    = 1'b1;
            w_daddr_nxt  = w_ea;
            w_dwdata_nxt = w_rb_data;
          end
          OP_LDM: begin
            w_go_mem    = 1'b1;
            w_dwe_nxt   = 1'b0;
            w_daddr_nxt = w_ea;
          end
          OP_JZ:  if (w_rb_data == '0) w_pc_nxt = ADDR_W'(w_imm);
          OP_JNZ: if (w_rb_data != '0) w_pc_nxt = ADDR_W'(w_imm);
          OP_CALL: begin
            w_go_mem     = 1'b1;
            w_dwe_nxt    = 1'b1;
            w_daddr_nxt  = w_sp_dec;
            w_dwdata_nxt = DATA_W'(r_pc);
          end
          OP_HALT: begin
            w_state_nxt = HALT;
            w_pc_nxt    = r_pc;
          end
        endcase
        // Memory ops defer pc/sp/register commit until the data ack
        if (w_go_mem) begin
          w_state_nxt = MEM;
          w_pc_nxt    = r_pc;
          w_dreq_nxt  = 1'b1;
        end
      end

      MEM: begin
        if (dmem_ack) begin
          w_state_nxt = FETCH;
          w_dreq_nxt  = 1'b0;
          w_dwe_nxt   = 1'b0;
          w_pc_nxt    = w_pc_inc;
          case (w_op)
            OP_ALU: begin
              case (w_sub)
                SUB_PUSH: w_sp_nxt = w_sp_dec;
                SUB_POP: begin
                  w_sp_nxt = w_sp_inc;
                  w_rf_we  = 1'b1;
                  w_rf_wd  = dmem_rdata;
                end
                SUB_RET: begin
                  w_sp_nxt = w_sp_inc;
                  w_pc_nxt = ADDR_W'(dmem_rdata) + ADDR_W'(1);
                end
                default: ;
              endcase
            end
            OP_LDM: begin
              w_rf_we = 1'b1;
              w_rf_wd = dmem_rdata;
            end
            OP_CALL: begin
              w_sp_nxt = w_sp_dec;
              w_pc_nxt = ADDR_W'(w_imm);
            end
            default: ;
          endcase
        end
      end

      HALT: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_ir     <= '0;
      r_pc     <= '0;
      r_sp     <= ADDR_W'(SP_RST);
      r_dreq   <= 1'b0;
      r_dwe    <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
    end else begin
      if (w_ir_load) r_ir <= imem_rdata;
      r_pc     <= w_pc_nxt;
      r_sp     <= w_sp_nxt;
      r_dreq   <= w_dreq_nxt;
      r_dwe    <= w_dwe_nxt;
      r_daddr  <= w_daddr_nxt;
      r_dwdata <= w_dwdata_nxt;
    end
  end

  // State resets to FETCH, so the fetch request is also gated by reset itself
  assign imem_req   = nRESET && (r_state == FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dreq;
  assign dmem_we    = r_dwe;
  assign dmem_addr  = r_daddr;
  assign dmem_wdata = r_dwdata;
  assign pc_out     = r_pc;
  assign sp_out     = r_sp;
  assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_minc_core_mc.sv
// Directed self-checking bench for minc_core_mc with wait-state memory models.
module tb_minc_core_mc;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [14:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  pc_out, sp_out;
  logic        halted;

  minc_core_mc dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc_out     (pc_out),
    .sp_out     (sp_out),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  // Memory models with programmable wait states
  logic [14:0] rom [256];
  logic [7:0]  ram [256];
  int   imem_delay = 0, dmem_delay = 0;
  int   imem_wait = 0, dmem_wait = 0;
  bit   dmem_hold = 1'b0, dmem_force = 1'b0;
  int   wr_cnt = 0;
  logic [7:0] last_waddr = 8'h00, last_wdata = 8'h00;

  assign imem_ack   = imem_req && (imem_wait >= imem_delay);
  assign imem_rdata = rom[imem_addr];
  assign dmem_ack   = (dmem_req && !dmem_hold && (dmem_wait >= dmem_delay)) || dmem_force;
  assign dmem_rdata = ram[dmem_addr];

  always @(posedge CLK) begin
    if (imem_req && !imem_ack) imem_wait <= imem_wait + 1;
    else                       imem_wait <= 0;
    if (dmem_req && !dmem_ack) dmem_wait <= dmem_wait + 1;
    else                       dmem_wait <= 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      ram[dmem_addr] <= dmem_wdata;
      last_waddr     <= dmem_addr;
      last_wdata     <= dmem_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
  end

  // Handshake monitor: stable request until ack, request low the cycle after ack
  bit         p_rst = 1'b0;
  logic       p_ireq, p_iack, p_dreq, p_dack, p_dwe;
  logic [7:0] p_iaddr, p_daddr, p_dwd;
  int         proto_err = 0;

  always @(negedge CLK) begin
    if (nRESET && p_rst) begin
      if (p_ireq && !p_iack && (!imem_req || imem_addr !== p_iaddr)) proto_err <= proto_err + 1;
      if (p_ireq && p_iack && imem_req) proto_err <= proto_err + 1;
      if (p_dreq && !p_dack && (!dmem_req || dmem_addr !== p_daddr ||
                                dmem_we !== p_dwe || dmem_wdata !== p_dwd))
        proto_err <= proto_err + 1;
      if (p_dreq && p_dack && dmem_req) proto_err <= proto_err + 1;
    end
    p_rst   <= nRESET;
    p_ireq  <= imem_req;
    p_iack  <= imem_ack;
    p_iaddr <= imem_addr;
    p_dreq  <= dmem_req;
    p_dack  <= dmem_ack;
    p_daddr <= dmem_addr;
    p_dwe   <= dmem_we;
    p_dwd   <= dmem_wdata;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] alu(input logic [3:0] sub, input logic [3:0] rd, input logic [3:0] rs);
    return {3'b000, sub, rd, rs};
  endfunction

  function automatic logic [14:0] opi(input logic [2:0] op, input logic [7:0] imm, input logic [3:0] r);
    return {op, imm, r};
  endfunction

  localparam logic [14:0] HLT = 15'h7000;

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = HLT;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRESET = 1'b0;
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
  endtask

  task automatic run_halt(input int max_cyc, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < max_cyc) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic wait_pc(input logic [7:0] target, input int max_cyc);
    int n;
    n = 0;
    while (pc_out !== target && n < max_cyc) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  int cyc;
  int wr_snap;

  initial begin
    // ---- Test 1: mvi/mvi/sub/HALT, zero-wait memories ----
    fill_rom();
    rom[0] = opi(3'b001, 8'h05, 4'd1);
    rom[1] = opi(3'b001, 8'h03, 4'd2);
    rom[2] = alu(4'h2, 4'd1, 4'd2);
    repeat (2) @(negedge CLK);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we",  dmem_we,  1'b0);
    check("rst_halted",   halted,   1'b0);
    check("rst_pc",       pc_out,   8'h00);
    check("rst_sp",       sp_out,   8'h00);
    nRESET = 1'b1;
    run_halt(100, cyc);
    check("t1_halt_cycle", cyc, 8);
    check("t1_pc", pc_out, 8'h03);
    check("t1_r1", dut.u_rf.r_regs[1], 8'h02);
    check("t1_r2", dut.u_rf.r_regs[2], 8'h03);
    repeat (3) @(posedge CLK);
    #1;
    check("t1_pc_frozen", pc_out, 8'h03);
    check("t1_halt_no_req", imem_req, 1'b0);
    check("t1_halted_held", halted, 1'b1);

    // ---- Test 2: same program, imem ack after 3 wait cycles ----
    imem_delay = 3;
    do_reset();
    run_halt(200, cyc);
    check("t2_halt_cycle", cyc, 20);
    check("t2_pc", pc_out, 8'h03);
    check("t2_r1", dut.u_rf.r_regs[1], 8'h02);
    check("t2_handshake", proto_err, 0);
    imem_delay = 0;

    // ---- Test 3: call 0x10 / ret ----
    fill_rom();
    rom[8'h00] = opi(3'b101, 8'h10, 4'd0);
    rom[8'h10] = alu(4'hC, 4'd0, 4'd0);
    wr_snap = wr_cnt;
    do_reset();
    wait_pc(8'h10, 50);
    check("t3_pc_at_callee", pc_out, 8'h10);
    check("t3_sp_after_call", sp_out, 8'hFF);
    check("t3_call_waddr", last_waddr, 8'hFF);
    check("t3_call_wdata", last_wdata, 8'h00);
    run_halt(100, cyc);
    check("t3_ret_pc", pc_out, 8'h01);
    check("t3_ret_sp", sp_out, 8'h00);
    check("t3_write_count", wr_cnt - wr_snap, 1);

    // ---- Test 4: stack wrap through push/sts/pop, 2 dmem wait cycles ----
    dmem_delay = 2;
    fill_rom();
    rom[0] = opi(3'b001, 8'hAA, 4'd1);
    rom[1] = alu(4'h9, 4'd0, 4'd0);
    rom[2] = alu(4'h8, 4'd0, 4'd1);
    rom[3] = alu(4'hB, 4'd4, 4'd0);
    rom[4] = alu(4'hA, 4'd3, 4'd0);
    do_reset();
    wait_pc(8'h03, 60);
    check("t4_pc_after_push", pc_out, 8'h03);
    check("t4_sp_after_push", sp_out, 8'hFF);
    check("t4_push_waddr", last_waddr, 8'hFF);
    check("t4_push_wdata", last_wdata, 8'hAA);
    run_halt(100, cyc);
    check("t4_r3_pop", dut.u_rf.r_regs[3], 8'hAA);
    check("t4_r4_sts", dut.u_rf.r_regs[4], 8'hFF);
    check("t4_sp_wrap", sp_out, 8'h00);
    check("t4_pc", pc_out, 8'h05);
    dmem_delay = 0;

    // ---- Test 5: unsigned cmp and jnz ----
    fill_rom();
    rom[0] = opi(3'b001, 8'h02, 4'd1);
    rom[1] = opi(3'b001, 8'h09, 4'd2);
    rom[2] = alu(4'h3, 4'd1, 4'd2);
    rom[3] = opi(3'b001, 8'h09, 4'd3);
    rom[4] = opi(3'b001, 8'h02, 4'd4);
    rom[5] = alu(4'h3, 4'd3, 4'd4);
    rom[6] = opi(3'b110, 8'h20, 4'd3);
    rom[7] = opi(3'b110, 8'h20, 4'd1);
    rom[8'h20] = opi(3'b001, 8'h5A, 4'd9);
    do_reset();
    wait_pc(8'h07, 60);
    check("t5_jnz_not_taken", pc_out, 8'h07);
    run_halt(100, cyc);
    check("t5_cmp_lt", dut.u_rf.r_regs[1], 8'h01);
    check("t5_cmp_ge", dut.u_rf.r_regs[3], 8'h00);
    check("t5_jnz_taken_r9", dut.u_rf.r_regs[9], 8'h5A);
    check("t5_pc", pc_out, 8'h21);

    // ---- Test 7: mul/add/mov/stm/ldm/jz and 8-bit wrap ----
    dmem_delay = 1;
    fill_rom();
    rom[0]  = opi(3'b001, 8'h40, 4'd15);
    rom[1]  = opi(3'b001, 8'h13, 4'd1);
    rom[2]  = opi(3'b001, 8'h11, 4'd2);
    rom[3]  = alu(4'h4, 4'd1, 4'd2);
    rom[4]  = alu(4'h1, 4'd1, 4'd2);
    rom[5]  = alu(4'h0, 4'd5, 4'd1);
    rom[6]  = opi(3'b010, 8'h05, 4'd5);
    rom[7]  = opi(3'b011, 8'h05, 4'd6);
    rom[8]  = opi(3'b100, 8'h30, 4'd1);
    rom[9]  = opi(3'b001, 8'h77, 4'd9);
    rom[10] = opi(3'b100, 8'h30, 4'd7);
    rom[8'h30] = opi(3'b001, 8'hFF, 4'd8);
    rom[8'h31] = alu(4'h1, 4'd8, 4'd2);
    do_reset();
    run_halt(200, cyc);
    check("t7_mul_add", dut.u_rf.r_regs[1], 8'h54);
    check("t7_mov", dut.u_rf.r_regs[5], 8'h54);
    check("t7_stm_waddr", last_waddr, 8'h45);
    check("t7_stm_wdata", last_wdata, 8'h54);
    check("t7_ldm", dut.u_rf.r_regs[6], 8'h54);
    check("t7_jz_not_taken", dut.u_rf.r_regs[9], 8'h77);
    check("t7_add_wrap", dut.u_rf.r_regs[8], 8'h10);
    check("t7_pc", pc_out, 8'h32);
    dmem_delay = 0;

    // ---- Test 6: reset while a dmem write is pending ----
    fill_rom();
    rom[0] = opi(3'b001, 8'h07, 4'd1);
    rom[1] = alu(4'h8, 4'd0, 4'd1);
    dmem_hold = 1'b1;
    wr_snap = wr_cnt;
    do_reset();
    for (int n = 0; n < 50 && dmem_req !== 1'b1; n++) begin
      @(posedge CLK); #1;
    end
    check("t6_push_req", dmem_req, 1'b1);
    check("t6_push_we", dmem_we, 1'b1);
    check("t6_push_addr", dmem_addr, 8'hFF);
    check("t6_push_wdata", dmem_wdata, 8'h07);
    #2;
    nRESET = 1'b0;
    #1;
    check("t6_req_drop", dmem_req, 1'b0);
    check("t6_rst_pc", pc_out, 8'h00);
    check("t6_rst_sp", sp_out, 8'h00);
    check("t6_rst_r1", dut.u_rf.r_regs[1], 8'h00);
    check("t6_rst_imem_req", imem_req, 1'b0);
    rom[1] = HLT;
    dmem_hold = 1'b0;
    dmem_force = 1'b1;
    @(negedge CLK);
    nRESET = 1'b1;
    run_halt(100, cyc);
    check("t6_late_ack_pc", pc_out, 8'h01);
    check("t6_late_ack_sp", sp_out, 8'h00);
    check("t6_late_ack_r1", dut.u_rf.r_regs[1], 8'h07);
    check("t6_no_write", wr_cnt - wr_snap, 0);
    dmem_force = 1'b0;

    check("handshake_total", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
